multi_axis_angle_controller: RTL and testbench

- Parametrised N-axis successor to the 3-axis angle-to-rate stage. Sits between the receiver/IMU fusion and the rate PID bank.
- Per axis: maps the receiver target, forms the angle (or rate-mode) error, scales it by a runtime-programmable multiplier and shift, and clamps it to a runtime-programmable symmetric limit.
- Axes are processed sequentially through one shared multiplier. Results are published atomically.

---
 rtl/multi_axis_angle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multi_axis_angle_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_angle_controller.sv
// N-axis angle-to-rate stage: map, scale and clamp each axis through
// one shared multiplier, publishing all axes together.
module multi_axis_angle_controller #(
  parameter int                  NUM_AXES      = 3,
  parameter int                  REC_WIDTH     = 8,
  parameter int                  RATE_WIDTH    = 16,
  parameter int                  TGT_SHIFT     = 2,
  parameter int                  MAP_OFFSET    = 500,
  parameter logic [NUM_AXES-1:0] INVERT_MASK   = 3'b010,
  parameter int                  DEFAULT_MULT  = 1,
  parameter int                  DEFAULT_SHIFT = 0,
  parameter int                  DEFAULT_LIMIT = 1600
) (
  input  logic                           us_clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_AXES*REC_WIDTH-1:0]  target_in,
  input  logic [NUM_AXES*RATE_WIDTH-1:0] actual_in,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_AXES)-1:0]    cfg_axis,
  input  logic [RATE_WIDTH-1:0]          cfg_mult,
  input  logic [4:0]                     cfg_shift,
  input  logic [RATE_WIDTH-2:0]          cfg_limit,
  input  logic                           cfg_rate_mode,
  output logic [NUM_AXES*RATE_WIDTH-1:0] rate_out,
  output logic [NUM_AXES*RATE_WIDTH-1:0] error_out,
  output logic                           busy,
  output logic                           complete,
  output logic                           overrun
);

  localparam int AW = $clog2(NUM_AXES);
  localparam int EW = RATE_WIDTH + 2;
  localparam int PW = 2 * RATE_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_AXES - 1);

  localparam logic signed [EW-1:0] E_MAX = EW'(2**(RATE_WIDTH-1) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(-(2**(RATE_WIDTH-1)));
  localparam logic signed [PW-1:0] P_MAX = PW'(2**(RATE_WIDTH-1) - 1);
  localparam logic signed [PW-1:0] P_MIN = PW'(-(2**(RATE_WIDTH-1)));

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_MAP, S_SCALE, S_CLAMP, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [RATE_WIDTH-1:0] r_cfg_mult  [NUM_AXES];
  logic        [4:0]            r_cfg_shift [NUM_AXES];
  logic        [RATE_WIDTH-2:0] r_cfg_lim   [NUM_AXES];
  logic        [NUM_AXES-1:0]   r_cfg_rm;

  logic signed [RATE_WIDTH-1:0] r_sh_mult  [NUM_AXES];
  logic        [4:0]            r_sh_shift [NUM_AXES];
  logic        [RATE_WIDTH-2:0] r_sh_lim   [NUM_AXES];
  logic        [NUM_AXES-1:0]   r_sh_rm;
  logic        [REC_WIDTH-1:0]  r_sh_tgt   [NUM_AXES];
  logic signed [RATE_WIDTH-1:0] r_sh_act   [NUM_AXES];

  logic        [AW-1:0]         r_axis;
  logic signed [RATE_WIDTH-1:0] r_e;
  logic signed [RATE_WIDTH-1:0] r_p;
  logic signed [RATE_WIDTH-1:0] r_err_buf  [NUM_AXES];
  logic signed [RATE_WIDTH-1:0] r_rate_buf [NUM_AXES];
  logic signed [RATE_WIDTH-1:0] r_err_out  [NUM_AXES];
  logic signed [RATE_WIDTH-1:0] r_rate_out [NUM_AXES];

  logic signed [EW-1:0]         w_tgt;
  logic signed [EW-1:0]         w_act;
  logic signed [EW-1:0]         w_sum;
  logic signed [RATE_WIDTH-1:0] w_e;
  logic signed [PW-1:0]         w_prod;
  logic signed [PW-1:0]         w_shr;
  logic signed [RATE_WIDTH-1:0] w_p;
  logic signed [RATE_WIDTH-1:0] w_lim;
  logic signed [RATE_WIDTH-1:0] w_r;

  always_ff @(posedge us_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        r_cfg_mult[i]  <= RATE_WIDTH'(DEFAULT_MULT);
        r_cfg_shift[i] <= 5'(DEFAULT_SHIFT);
        r_cfg_lim[i]   <= (RATE_WIDTH-1)'(DEFAULT_LIMIT);
      end
      r_cfg_rm <= '0;
    end else if (cfg_we && cfg_axis <= LAST) begin
      r_cfg_mult[cfg_axis]  <= cfg_mult;
      r_cfg_shift[cfg_axis] <= cfg_shift;
      r_cfg_lim[cfg_axis]   <= cfg_limit;
      r_cfg_rm[cfg_axis]    <= cfg_rate_mode;
    end
  end

  always_ff @(posedge us_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    complete = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LATCH;
      end
      S_LATCH: w_next = S_MAP;
      S_MAP:   w_next = S_SCALE;
      S_SCALE: w_next = S_CLAMP;
      S_CLAMP: w_next = (r_axis == LAST) ? S_DONE : S_MAP;
      S_DONE: begin
        complete = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    overrun = start && busy;
  end

  // Error at two extra bits so the sum never wraps before saturation
  always_comb begin
    w_tgt = $signed(EW'(r_sh_tgt[r_axis]) << TGT_SHIFT);
    w_act = EW'(r_sh_act[r_axis]);
    w_sum = w_tgt - EW'(MAP_OFFSET);
    if (!r_sh_rm[r_axis]) begin
      if (INVERT_MASK[r_axis]) w_sum = w_sum + w_act;
      else                     w_sum = w_sum - w_act;
    end
    if (w_sum > E_MAX)      w_e = E_MAX[RATE_WIDTH-1:0];
    else if (w_sum < E_MIN) w_e = E_MIN[RATE_WIDTH-1:0];
    else                    w_e = w_sum[RATE_WIDTH-1:0];
  end

  always_comb begin
    w_prod = PW'(r_e) * PW'(r_sh_mult[r_axis]);
    w_shr  = w_prod >>> r_sh_shift[r_axis];
    if (w_shr > P_MAX)      w_p = P_MAX[RATE_WIDTH-1:0];
    else if (w_shr < P_MIN) w_p = P_MIN[RATE_WIDTH-1:0];
    else                    w_p = w_shr[RATE_WIDTH-1:0];
  end

  always_comb begin
    w_lim = $signed({1'b0, r_sh_lim[r_axis]});
    if (r_p > w_lim)       w_r = w_lim;
    else if (r_p < -w_lim) w_r = -w_lim;
    else                   w_r = r_p;
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      r_axis <= '0;
      r_e    <= '0;
      r_p    <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        r_err_out[i]  <= '0;
        r_rate_out[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_LATCH: begin
          r_axis     <= '0;
          r_sh_mult  <= r_cfg_mult;
          r_sh_shift <= r_cfg_shift;
          r_sh_lim   <= r_cfg_lim;
          r_sh_rm    <= r_cfg_rm;
          for (int i = 0; i < NUM_AXES; i++) begin
            r_sh_tgt[i] <= target_in[i*REC_WIDTH +: REC_WIDTH];
            r_sh_act[i] <= actual_in[i*RATE_WIDTH +: RATE_WIDTH];
          end
        end
        S_MAP: begin
          r_e               <= w_e;
          r_err_buf[r_axis] <= w_e;
        end
        S_SCALE: r_p <= w_p;
        S_CLAMP: begin
          r_rate_buf[r_axis] <= w_r;
          // Publish on the last axis so outputs are valid with complete
          if (r_axis == LAST) begin
            for (int i = 0; i < NUM_AXES; i++) begin
              r_err_out[i]  <= r_err_buf[i];
              r_rate_out[i] <= (AW'(i) == r_axis) ? w_r : r_rate_buf[i];
            end
          end else begin
            r_axis <= r_axis + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_pack
    assign rate_out[g*RATE_WIDTH +: RATE_WIDTH]  = r_rate_out[g];
    assign error_out[g*RATE_WIDTH +: RATE_WIDTH] = r_err_out[g];
  end

endmodule

// File: tb/tb_multi_axis_angle_controller.sv
// Bench for multi_axis_angle_controller: table vectors, corner sequences
// and randomized runs against an arithmetic reference model.
module tb_multi_axis_angle_controller;

  localparam int N = 3;

  logic        us_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] target_in;
  logic [47:0] actual_in;
  logic        cfg_we;
  logic [1:0]  cfg_axis;
  logic [15:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic [14:0] cfg_limit;
  logic        cfg_rate_mode;
  logic [47:0] rate_out;
  logic [47:0] error_out;
  logic        busy;
  logic        complete;
  logic        overrun;

  multi_axis_angle_controller dut (
    .us_clk(us_clk), .reset(reset), .start(start),
    .target_in(target_in), .actual_in(actual_in),
    .cfg_we(cfg_we), .cfg_axis(cfg_axis), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_limit(cfg_limit),
    .cfg_rate_mode(cfg_rate_mode),
    .rate_out(rate_out), .error_out(error_out),
    .busy(busy), .complete(complete), .overrun(overrun)
  );

  always #5 us_clk = ~us_clk;

  typedef struct {
    logic [23:0] tgt;
    logic [47:0] act;
    logic [47:0] err;
    logic [47:0] rate;
  } vec_t;

  vec_t tbl [4];
  int n_chk = 0;
  int n_fail = 0;
  int m_mult [N];
  int m_shift [N];
  int m_lim [N];
  bit m_rm [N];
  logic [2:0] inv_mask = 3'b010;
  int cur_t [N];
  int cur_a [N];

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model(input int a, input int t, input int ac,
                                output longint e, output longint r);
    longint p, lim;
    e = longint'(t) * 4 - 500;
    if (!m_rm[a]) e = inv_mask[a] ? e + ac : e - ac;
    e = sat(e);
    p = sat((e * m_mult[a]) >>> m_shift[a]);
    lim = m_lim[a];
    r = (p > lim) ? lim : ((p < -lim) ? -lim : p);
  endfunction

  function automatic longint rate_of(input int a);
    return longint'($signed(rate_out[a*16 +: 16]));
  endfunction

  function automatic longint err_of(input int a);
    return longint'($signed(error_out[a*16 +: 16]));
  endfunction

  task automatic model_defaults();
    for (int i = 0; i < N; i++) begin
      m_mult[i] = 1; m_shift[i] = 0; m_lim[i] = 1600; m_rm[i] = 0;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      target_in[i*8 +: 8]  = 8'(cur_t[i]);
      actual_in[i*16 +: 16] = 16'(cur_a[i]);
    end
  endtask

  task automatic cfg_write(input int a, input int mult, input int sh,
                           input int lim, input bit rm);
    @(negedge us_clk);
    cfg_we = 1'b1; cfg_axis = 2'(a); cfg_mult = 16'(mult);
    cfg_shift = 5'(sh); cfg_limit = 15'(lim); cfg_rate_mode = rm;
    @(negedge us_clk);
    cfg_we = 1'b0;
    if (a < N) begin
      m_mult[a] = mult; m_shift[a] = sh; m_lim[a] = lim; m_rm[a] = rm;
    end
  endtask

  // Returns at the negedge where complete is seen (or the bound expires)
  task automatic run_once(output int cyc, output int bcyc);
    @(negedge us_clk);
    apply_inputs();
    start = 1'b1;
    @(negedge us_clk);
    start = 1'b0;
    cyc = 1;
    bcyc = int'(busy);
    while (!complete && cyc < 40) begin
      @(negedge us_clk);
      cyc++;
      bcyc += int'(busy);
    end
    chk("latency", cyc, 11);
  endtask

  task automatic check_model(input string tag);
    longint e, r;
    for (int i = 0; i < N; i++) begin
      model(i, cur_t[i], cur_a[i], e, r);
      chk($sformatf("%s err%0d", tag, i), err_of(i), e);
      chk($sformatf("%s rate%0d", tag, i), rate_of(i), r);
    end
  endtask

  initial begin
    int cyc, bcyc, c1, c2;

    tbl[0] = '{tgt: {8'd125, 8'd125, 8'd125}, act: 48'd0,
               err: 48'd0, rate: 48'd0};
    tbl[1] = '{tgt: {8'd255, 8'd250, 8'd250},
               act: {-16'sd2000, 16'sd16, 16'sd16},
               err: {16'sd2520, 16'sd516, 16'sd484},
               rate: {16'sd1600, 16'sd516, 16'sd484}};
    tbl[2] = '{tgt: {8'd255, 8'd250, 8'd250},
               act: {16'sd2000, 16'sd16, 16'sd16},
               err: {-16'sd1480, 16'sd516, 16'sd484},
               rate: {-16'sd1480, 16'sd516, 16'sd484}};
    tbl[3] = '{tgt: {8'd128, 8'd255, 8'd0},
               act: {16'sd12, 16'sd32767, 16'sd32767},
               err: {16'sd0, 16'sd32767, 16'h8000},
               rate: {16'sd0, 16'sd1600, -16'sd1600}};

    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_axis = '0;
    cfg_mult = '0; cfg_shift = '0; cfg_limit = '0; cfg_rate_mode = 1'b0;
    target_in = '0; actual_in = '0;
    for (int i = 0; i < N; i++) begin cur_t[i] = 0; cur_a[i] = 0; end
    model_defaults();
    repeat (3) @(negedge us_clk);
    chk("rst busy", busy, 0);
    chk("rst complete", complete, 0);
    chk("rst overrun", overrun, 0);
    chk("rst rate_out", rate_out, 0);
    chk("rst error_out", error_out, 0);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        cur_t[i] = int'(tbl[k].tgt[i*8 +: 8]);
        cur_a[i] = int'($signed(tbl[k].act[i*16 +: 16]));
      end
      run_once(cyc, bcyc);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("vec%0d err%0d", k, i), err_of(i),
            longint'($signed(tbl[k].err[i*16 +: 16])));
        chk($sformatf("vec%0d rate%0d", k, i), rate_of(i),
            longint'($signed(tbl[k].rate[i*16 +: 16])));
      end
      if (k == 0) begin
        chk("busy cycles", bcyc, 11);
        @(negedge us_clk);
        chk("busy after done", busy, 0);
        chk("complete one cycle", complete, 0);
      end
    end

    // Multiplier saturation, then rate mode ignoring the actual
    cfg_write(0, 32767, 0, 32767, 0);
    cur_t[0] = 250; cur_t[1] = 125; cur_t[2] = 125;
    cur_a[0] = 0; cur_a[1] = 0; cur_a[2] = 0;
    run_once(cyc, bcyc);
    chk("msat err0", err_of(0), 500);
    chk("msat rate0", rate_of(0), 32767);
    check_model("msat");
    cfg_write(0, 32767, 0, 32767, 1);
    cur_a[0] = 999;
    run_once(cyc, bcyc);
    chk("rmode err0", err_of(0), 500);
    check_model("rmode");

    // Overrun mid-run plus a config write that must not affect this run
    @(negedge us_clk);
    apply_inputs();
    start = 1'b1;
    @(negedge us_clk);
    start = 1'b0;
    repeat (3) @(negedge us_clk);
    start = 1'b1;
    #1 chk("overrun c4", overrun, 1);
    @(negedge us_clk);
    start = 1'b0;
    cfg_we = 1'b1; cfg_axis = 2'd0; cfg_mult = 16'sd32767;
    cfg_shift = 5'd0; cfg_limit = 15'd10; cfg_rate_mode = 1'b1;
    #1 chk("overrun c5", overrun, 0);
    @(negedge us_clk);
    cfg_we = 1'b0;
    repeat (5) @(negedge us_clk);
    chk("ovr complete c11", complete, 1);
    chk("ovr old limit rate0", rate_of(0), 32767);
    @(negedge us_clk);
    chk("no restart busy", busy, 0);
    m_lim[0] = 10;
    run_once(cyc, bcyc);
    chk("new limit rate0", rate_of(0), 10);
    check_model("newlim");

    // Start held high: back-to-back runs, start in DONE is an overrun
    c1 = -1; c2 = -1;
    @(negedge us_clk);
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge us_clk);
      if (complete) begin
        if (c1 < 0) c1 = c;
        else if (c2 < 0) c2 = c;
      end
      if (c == 11) chk("overrun in done", overrun, 1);
      if (c == 23) start = 1'b0;
    end
    chk("b2b first", c1, 11);
    chk("b2b second", c2, 23);

    // Reset in the middle of a run
    cur_t[0] = 200; cur_a[0] = 40;
    @(negedge us_clk);
    apply_inputs();
    start = 1'b1;
    @(negedge us_clk);
    start = 1'b0;
    repeat (5) @(negedge us_clk);
    reset = 1'b1;
    @(negedge us_clk);
    chk("midrst busy", busy, 0);
    chk("midrst complete", complete, 0);
    chk("midrst overrun", overrun, 0);
    chk("midrst rate_out", rate_out, 0);
    chk("midrst error_out", error_out, 0);
    reset = 1'b0;
    model_defaults();
    run_once(cyc, bcyc);
    check_model("postrst");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int a, mult, sh, lim;
        bit rm;
        a = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) mult = int'($urandom_range(0, 16)) - 8;
        else mult = int'($signed(16'($urandom)));
        sh = int'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) lim = int'($urandom_range(0, 32767));
        else lim = int'($urandom_range(0, 2000));
        rm = ($urandom_range(0, 3) == 0);
        cfg_write(a, mult, sh, lim, rm);
      end
      for (int i = 0; i < N; i++) begin
        cur_t[i] = int'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) cur_a[i] = int'($signed(16'($urandom)));
        else cur_a[i] = int'($urandom_range(0, 4000)) - 2000;
      end
      run_once(cyc, bcyc);
      check_model($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
